// File: rtl/shift_sequencer.sv
// Sequencer driving mode pins and end fill bits for a chain of universal shift-register slices.
// Latency: done pulses 1+load_first+count cycles after start is sampled.
// Backpressure: start is accepted only while ready=1; a start at any other time is dropped.
module shift_sequencer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_first,
  input  logic             dir,
  input  logic [1:0]       fill_sel,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic             msb_q,
  input  logic             lsb_q,
  output logic             op2,
  output logic             op1,
  output logic             shft0in,
  output logic             shft3in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             dir_q, dir_nxt;
  logic [1:0]       fill_q, fill_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dir_q  <= 1'b0;
      fill_q <= 2'b00;
      rem_q  <= '0;
    end else begin
      state  <= state_nxt;
      dir_q  <= dir_nxt;
      fill_q <= fill_nxt;
      rem_q  <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    fill_nxt  = fill_q;
    rem_nxt   = rem_q;
    op2       = 1'b1;
    op1       = 1'b1;
    shft0in   = 1'b0;
    shft3in   = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          dir_nxt  = dir;
          fill_nxt = fill_sel;
          rem_nxt  = count;
          if (load_first)       state_nxt = LOAD;
          else if (count != '0) state_nxt = SHIFT;
          else                  state_nxt = DONE;
        end
      end
      LOAD: begin
        busy = 1'b1;
        op2  = 1'b0;
        op1  = 1'b0;
        if (abort) begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end else begin
          state_nxt = (rem_q != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        op2  = dir_q;
        op1  = ~dir_q;
        // Fill is combinational on the live end bits so rotate/sign see the current chain.
        if (dir_q) begin
          case (fill_q)
            2'b00:   shft0in = 1'b0;
            2'b01:   shft0in = 1'b1;
            2'b10:   shft0in = msb_q;
            default: shft0in = lsb_q;
          endcase
        end else begin
          case (fill_q)
            2'b01:   shft3in = 1'b1;
            2'b11:   shft3in = msb_q;
            default: shft3in = 1'b0;
          endcase
        end
        if (abort) begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end else begin
          if (rem_q != '0) rem_nxt = rem_q - 1'b1;
          if (rem_q <= 1)  state_nxt = DONE;
        end
      end
      default: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with an 8-bit chain model driven by the mode pins.
module tb_shift_sequencer;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             load_first = 1'b0;
  logic             dir = 1'b0;
  logic [1:0]       fill_sel = 2'b00;
  logic [CNT_W-1:0] count = '0;
  logic             abort = 1'b0;
  logic             msb_q, lsb_q;
  logic             op2, op1, shft0in, shft3in, ready, busy, done;
  logic [CNT_W-1:0] remaining;

  logic [7:0] chain = 8'h00;
  logic [7:0] load_val = 8'h00;
  logic [7:0] preset_val = 8'h00;
  logic       preset_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int n;

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_first(load_first), .dir(dir),
    .fill_sel(fill_sel), .count(count), .abort(abort), .msb_q(msb_q), .lsb_q(lsb_q),
    .op2(op2), .op1(op1), .shft0in(shft0in), .shft3in(shft3in), .ready(ready),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Index 0 of the slice chain is bit 7 here; SHIFTL moves bits toward bit 0.
  assign msb_q = chain[7];
  assign lsb_q = chain[0];

  always @(posedge clk) begin
    if (preset_en) chain <= preset_val;
    else case ({op2, op1})
      2'b00: chain <= load_val;
      2'b01: chain <= {chain[6:0], shft3in};
      2'b10: chain <= {shft0in, chain[7:1]};
      default: chain <= chain;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [7:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic issue(input logic lf, input logic d, input logic [1:0] f, input logic [CNT_W-1:0] c);
    load_first = lf; dir = d; fill_sel = f; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mode"}, {op2, op1}, 2'b11);
    chk({tag, "_rdy"}, ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rem"}, remaining, 0);
    chk({tag, "_sin"}, {shft0in, shft3in}, 2'b00);
  endtask

  initial begin
    // 1: reset values, then idle
    #12;
    chk_idle("rst");
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_idle("idle5");

    // 2: LOAD then 3 SHIFTL zero fill, 0xF0 -> 0x1E
    load_val = 8'hF0;
    issue(1'b1, 1'b1, 2'b00, 6'd3);
    chk("t2_load", {op2, op1}, 2'b00);
    chk("t2_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_shl", {op2, op1}, 2'b10);
      chk("t2_rem", remaining, 3 - i);
    end
    tick();
    chk("t2_done", done, 1'b1);
    chk("t2_hold", {op2, op1}, 2'b11);
    chk("t2_data", chain, 8'h1E);
    tick();
    chk("t2_pulse", done, 1'b0);

    // 3: SHIFTL sign fill, 0x80 -> 0xE0, done at N+3
    preset(8'h80);
    issue(1'b0, 1'b1, 2'b10, 6'd2);
    for (int i = 0; i < 2; i++) begin
      chk("t3_shl", {op2, op1}, 2'b10);
      chk("t3_sin0", shft0in, chain[7]);
      chk("t3_sin3", shft3in, 1'b0);
      tick();
    end
    chk("t3_done", done, 1'b1);
    chk("t3_data", chain, 8'hE0);
    tick();

    // 4: SHIFTR rotate, 0xA5 -> 0x5A
    preset(8'hA5);
    issue(1'b0, 1'b0, 2'b11, 6'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_shr", {op2, op1}, 2'b01);
      chk("t4_sin3", shft3in, chain[7]);
      chk("t4_sin0", shft0in, 1'b0);
      tick();
    end
    chk("t4_done", done, 1'b1);
    chk("t4_data", chain, 8'h5A);
    tick();

    // 5: count 0 -> done at N+1; start during DONE ignored
    issue(1'b0, 1'b1, 2'b01, 6'd0);
    chk("t5_done", done, 1'b1);
    chk("t5_rdy", ready, 1'b0);
    chk("t5_mode", {op2, op1}, 2'b11);
    count = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("t5_ign");
    tick();
    chk_idle("t5_ign2");

    // abort and start in the same idle cycle: start wins
    abort = 1'b1;
    issue(1'b0, 1'b0, 2'b00, 6'd2);
    abort = 1'b0;
    chk("as_busy", busy, 1'b1);
    chk("as_mode", {op2, op1}, 2'b01);
    tick();
    tick();
    chk("as_done", done, 1'b1);
    tick();

    // maximum count: no wrap, 64 edges to done
    issue(1'b0, 1'b1, 2'b00, 6'd63);
    chk("max_rem", remaining, 63);
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("max_lat", n, 64);
    chk("max_rem0", remaining, 0);
    tick();

    // 6: abort mid-SHIFT, then reset mid-SHIFT
    issue(1'b0, 1'b0, 2'b00, 6'd10);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_rem", remaining, 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("t6_abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_nodone", done, 1'b0);
    end
    issue(1'b0, 1'b1, 2'b01, 6'd10);
    tick();
    chk("t6_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_idle("t6_rst");
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk_idle("t6_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
